// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode definitions: field positions, opcode constants,
// decode FSM state encoding and the single-instruction decode helper.
package decode_stage_pkg;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;

  // Opcodes that change destination or source usage
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] REG_LINK = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_READ  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        writes;
    logic        rs_used;
    logic        rt_used;
  } decoded_t;

  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t d;
    logic [4:0] rd;
    d.opcode = instr[OPCODE_LSB +: 6];
    d.funct  = instr[FUNCT_LSB +: 6];
    d.rs     = instr[RS_LSB +: 5];
    d.rt     = instr[RT_LSB +: 5];
    rd       = instr[RD_LSB +: 5];
    d.imm    = {{16{instr[IMM_LSB + 15]}}, instr[IMM_LSB +: 16]};
    case (d.opcode)
      OP_RTYPE:                    begin d.dest = rd;       d.writes = 1'b1; end
      OP_JAL:                      begin d.dest = REG_LINK; d.writes = 1'b1; end
      OP_J, OP_BEQ, OP_BNE, OP_SW: begin d.dest = 5'd0;     d.writes = 1'b0; end
      default:                     begin d.dest = d.rt;     d.writes = 1'b1; end
    endcase
    // Jumps carry a target in the register fields, so neither source is real
    d.rs_used = !((d.opcode == OP_J) || (d.opcode == OP_JAL));
    d.rt_used = (d.opcode == OP_RTYPE) || (d.opcode == OP_BEQ) ||
                (d.opcode == OP_BNE)   || (d.opcode == OP_SW);
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: one set port (issue), one clear port
// (writeback), two query ports that see a same-cycle clear as not busy.
module reg_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] qa_addr,
  output logic       qa_busy,
  input  logic [4:0] qb_addr,
  output logic       qb_busy
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Next busy vector: clear first so a coincident set to the same register wins
  always_comb begin
    // NOTE: start from the held value so every path assigns busy_d and no latch is inferred.
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Queries bypass a clear landing this cycle so a waiting reader is released immediately
  assign qa_busy = busy_q[qa_addr] & ~(clr_en & (clr_addr == qa_addr));
  assign qb_busy = busy_q[qb_addr] & ~(clr_en & (clr_addr == qb_addr));

  // Busy register; 32 flops, small enough to reset as a whole
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_stage.sv
// Single-issue MIPS decode stage: accept one instruction, wait for its
// sources to be free, read the register file, present it to execute.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        rf_ena,
  output logic [4:0]  rf_addra,
  input  logic [31:0] rf_dataa,
  output logic        rf_enb,
  output logic [4:0]  rf_addrb,
  input  logic [31:0] rf_datab,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_writes
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        if_ready_q, if_ready_d;
  logic        rf_ena_q, rf_ena_d;
  logic [4:0]  rf_addra_q, rf_addra_d;
  logic [4:0]  rf_addrb_q, rf_addrb_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [5:0]  ex_opcode_q, ex_opcode_d;
  logic [5:0]  ex_funct_q, ex_funct_d;
  logic [31:0] ex_rs_data_q, ex_rs_data_d;
  logic [31:0] ex_rt_data_q, ex_rt_data_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_dest_q, ex_dest_d;
  logic        ex_writes_q, ex_writes_d;

  decoded_t dec;
  logic     rs_busy, rt_busy, hazard, sb_set;

  assign dec    = decode_instr(instr_q);
  assign hazard = (dec.rs_used & rs_busy) | (dec.rt_used & rt_busy);

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (ex_dest_q),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .qa_addr  (dec.rs),
    .qa_busy  (rs_busy),
    .qb_addr  (dec.rt),
    .qb_busy  (rt_busy)
  );

  // Next-state and next-output logic; flush overrides everything last
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    if_ready_d   = if_ready_q;
    rf_ena_d     = 1'b0;
    rf_addra_d   = rf_addra_q;
    rf_addrb_d   = rf_addrb_q;
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_opcode_d  = ex_opcode_q;
    ex_funct_d   = ex_funct_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_dest_d    = ex_dest_q;
    ex_writes_d  = ex_writes_q;
    sb_set       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_valid && if_ready_q) begin
          instr_d    = if_instr;
          pc_d       = if_pc;
          if_ready_d = 1'b0;
          state_d    = ST_CHECK;
        end else begin
          if_ready_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!hazard) begin
          rf_ena_d   = 1'b1;
          rf_addra_d = dec.rs;
          rf_addrb_d = dec.rt;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        ex_rs_data_d = rf_dataa;
        ex_rt_data_d = rf_datab;
        ex_pc_d      = pc_q;
        ex_opcode_d  = dec.opcode;
        ex_funct_d   = dec.funct;
        ex_imm_d     = dec.imm;
        ex_dest_d    = dec.dest;
        ex_writes_d  = dec.writes;
        ex_valid_d   = 1'b1;
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        if (ex_ready) begin
          sb_set     = ex_writes_q && (ex_dest_q != 5'd0);
          ex_valid_d = 1'b0;
          if_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      sb_set     = 1'b0;
      rf_ena_d   = 1'b0;
      ex_valid_d = 1'b0;
      if_ready_d = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  // All FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      pc_q         <= '0;
      if_ready_q   <= 1'b0;
      rf_ena_q     <= 1'b0;
      rf_addra_q   <= '0;
      rf_addrb_q   <= '0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_opcode_q  <= '0;
      ex_funct_q   <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_dest_q    <= '0;
      ex_writes_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      if_ready_q   <= if_ready_d;
      rf_ena_q     <= rf_ena_d;
      rf_addra_q   <= rf_addra_d;
      rf_addrb_q   <= rf_addrb_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_opcode_q  <= ex_opcode_d;
      ex_funct_q   <= ex_funct_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_dest_q    <= ex_dest_d;
      ex_writes_q  <= ex_writes_d;
    end
  end

  assign if_ready   = if_ready_q;
  assign rf_ena     = rf_ena_q;
  assign rf_enb     = rf_ena_q;
  assign rf_addra   = rf_addra_q;
  assign rf_addrb   = rf_addrb_q;
  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_opcode  = ex_opcode_q;
  assign ex_funct   = ex_funct_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_dest    = ex_dest_q;
  assign ex_writes  = ex_writes_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-result queue for issued instructions.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        rf_ena, rf_enb;
  logic [4:0]  rf_addra, rf_addrb;
  logic [31:0] rf_dataa, rf_datab;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_dest;
  logic        ex_writes;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        writes;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf_mem [32];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  // Register file model: asynchronous read, poisoned when not enabled
  assign rf_dataa = rf_ena ? rf_mem[rf_addra] : 32'hDEAD_BEEF;
  assign rf_datab = rf_enb ? rf_mem[rf_addrb] : 32'hDEAD_BEEF;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_ena(rf_ena), .rf_addra(rf_addra), .rf_dataa(rf_dataa),
    .rf_enb(rf_enb), .rf_addrb(rf_addrb), .rf_datab(rf_datab),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_writes(ex_writes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm,
                          input logic [4:0] dest, input logic writes);
    exp_t e;
    e.pc = pc; e.opcode = op; e.funct = fn;
    e.rs_data = rf_mem[rs]; e.rt_data = rf_mem[rt];
    e.imm = imm; e.dest = dest; e.writes = writes;
    exp_q.push_back(e);
  endtask

  // Offer one instruction; returns after the accept edge (stage now in CHECK)
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    int n = 0;
    while (!if_ready && n < 20) begin tick(); n++; end
    check("if_ready_before_issue", if_ready, 1);
    if_valid = 1'b1; if_instr = instr; if_pc = pc;
    tick();
    if_valid = 1'b0;
  endtask

  // From the accept edge: CHECK, READ (rf enables), then OUT with ex_valid
  task automatic fast_path(input logic [4:0] rs, input logic [4:0] rt);
    check("check_ex_valid", ex_valid, 0);
    check("check_rf_ena", rf_ena, 0);
    tick();
    check("read_rf_ena", rf_ena, 1);
    check("read_rf_enb", rf_enb, 1);
    check("read_rf_addra", rf_addra, rs);
    check("read_rf_addrb", rf_addrb, rt);
    check("read_ex_valid", ex_valid, 0);
    tick();
    check("out_ex_valid", ex_valid, 1);
    check("out_rf_ena", rf_ena, 0);
  endtask

  task automatic check_ex(input string tag);
    exp_t e;
    check({tag, "_queue"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, ex_pc, e.pc);
      check({tag, "_opcode"}, ex_opcode, e.opcode);
      check({tag, "_funct"}, ex_funct, e.funct);
      check({tag, "_rs_data"}, ex_rs_data, e.rs_data);
      check({tag, "_rt_data"}, ex_rt_data, e.rt_data);
      check({tag, "_imm"}, ex_imm, e.imm);
      check({tag, "_dest"}, ex_dest, e.dest);
      check({tag, "_writes"}, ex_writes, e.writes);
    end
  endtask

  task automatic handshake();
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    check("post_handshake_ex_valid", ex_valid, 0);
  endtask

  task automatic wb(input logic [4:0] addr);
    wb_valid = 1'b1; wb_addr = addr;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA500_0000 | (32'(i) * 32'h0101);
    rst = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0;
    wb_valid = 0; wb_addr = 0; flush = 0; ex_ready = 0;
    tick(); tick();

    // Reset values
    check("rst_if_ready", if_ready, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_rf_ena", rf_ena, 0);
    check("rst_rf_addra", rf_addra, 0);
    check("rst_ex_dest", ex_dest, 0);
    check("rst_ex_writes", ex_writes, 0);
    check("rst_ex_rs_data", ex_rs_data, 0);
    check("rst_busy", dut.u_sb.busy_q, 0);
    rst = 1'b0;
    tick();
    check("post_rst_if_ready", if_ready, 1);

    // add $3,$1,$2
    push_exp(32'h100, 6'h00, 6'h20, 1, 2, 32'h0000_1820, 3, 1);
    issue(32'h0022_1820, 32'h100);
    check("accept_if_ready", if_ready, 0);
    fast_path(1, 2);
    check_ex("add");
    handshake();
    check("add_busy", dut.u_sb.busy_q, 32'h0000_0008);

    // addi $4,$3,-1 stalls on $3 until writeback releases it in the same cycle
    push_exp(32'h104, 6'h08, 6'h3F, 3, 4, 32'hFFFF_FFFF, 4, 1);
    issue(32'h2064_FFFF, 32'h104);
    tick();
    check("addi_stall1_rf_ena", rf_ena, 0);
    tick();
    check("addi_stall2_rf_ena", rf_ena, 0);
    check("addi_stall_ex_valid", ex_valid, 0);
    wb(3);
    check("addi_release_rf_ena", rf_ena, 1);
    check("addi_release_rf_addra", rf_addra, 3);
    check("addi_busy_cleared", dut.u_sb.busy_q, 0);
    tick();
    check("addi_ex_valid", ex_valid, 1);
    check_ex("addi");
    handshake();
    check("addi_busy", dut.u_sb.busy_q, 32'h0000_0010);
    wb(4);
    check("busy_clear4", dut.u_sb.busy_q, 0);

    // Make $5 and $6 busy, then sw $5,8($6) must wait for both
    push_exp(32'h108, 6'h08, 6'h01, 0, 5, 32'h1, 5, 1);
    issue(32'h2005_0001, 32'h108);
    fast_path(0, 5); check_ex("addi5"); handshake();
    push_exp(32'h10C, 6'h08, 6'h02, 0, 6, 32'h2, 6, 1);
    issue(32'h2006_0002, 32'h10C);
    fast_path(0, 6); check_ex("addi6"); handshake();
    check("busy_5_6", dut.u_sb.busy_q, 32'h0000_0060);
    push_exp(32'h110, 6'h2B, 6'h08, 6, 5, 32'h8, 0, 0);
    issue(32'hACC5_0008, 32'h110);
    tick();
    check("sw_stall_both", rf_ena, 0);
    wb(6);
    check("sw_stall_rt", rf_ena, 0);
    check("sw_busy_5", dut.u_sb.busy_q, 32'h0000_0020);
    wb(5);
    check("sw_rf_ena", rf_ena, 1);
    check("sw_rf_addra", rf_addra, 6);
    check("sw_rf_addrb", rf_addrb, 5);
    tick();
    check("sw_ex_valid", ex_valid, 1);
    check_ex("sw");
    handshake();
    check("sw_no_busy", dut.u_sb.busy_q, 0);

    // Fill the scoreboard: addi $i,$0,i for i = 1..31
    for (int i = 1; i < 32; i++) begin
      ins = 32'h2000_0000 | (32'(i) << 16) | 32'(i);
      push_exp(32'h200 + 32'(i) * 4, 6'h08, 6'(i), 0, 5'(i), 32'(i), 5'(i), 1);
      issue(ins, 32'h200 + 32'(i) * 4);
      fast_path(0, 5'(i));
      check_ex("fill");
      handshake();
    end
    check("busy_full", dut.u_sb.busy_q, 32'hFFFF_FFFE);

    // jal never stalls on its register fields
    push_exp(32'h300, 6'h03, 6'h10, 0, 0, 32'h10, 31, 1);
    issue(32'h0C00_0010, 32'h300);
    fast_path(0, 0);
    check_ex("jal");
    handshake();
    push_exp(32'h304, 6'h03, 6'h10, 31, 31, 32'h10, 31, 1);
    issue(32'h0FFF_0010, 32'h304);
    fast_path(31, 31);
    check_ex("jal_rs31");
    handshake();
    check("jal_busy", dut.u_sb.busy_q, 32'hFFFF_FFFE);
    for (int i = 1; i < 32; i++) wb(5'(i));
    check("busy_drained", dut.u_sb.busy_q, 0);

    // Back-pressure: outputs hold while ex_ready stays low
    push_exp(32'h400, 6'h00, 6'h20, 1, 2, 32'h0000_1820, 3, 1);
    issue(32'h0022_1820, 32'h400);
    fast_path(1, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ex_valid", ex_valid, 1);
      check("hold_ex_pc", ex_pc, exp_q[0].pc);
      check("hold_ex_rs_data", ex_rs_data, exp_q[0].rs_data);
      check("hold_ex_dest", ex_dest, exp_q[0].dest);
    end
    check_ex("hold");
    handshake();
    check("hold_busy", dut.u_sb.busy_q, 32'h0000_0008);

    // Flush in OUT beats a simultaneous handshake: no emit, no busy set
    push_exp(32'h404, 6'h00, 6'h20, 4, 5, 32'h0000_3020, 6, 1);
    issue(32'h0085_3020, 32'h404);
    fast_path(4, 5);
    flush = 1'b1; ex_ready = 1'b1;
    tick();
    flush = 1'b0; ex_ready = 1'b0;
    void'(exp_q.pop_front());
    check("flush_ex_valid", ex_valid, 0);
    check("flush_busy", dut.u_sb.busy_q, 32'h0000_0008);
    check("flush_if_ready", if_ready, 1);

    // Set and clear of $7 in the same cycle: set wins
    push_exp(32'h408, 6'h08, 6'h07, 0, 7, 32'h7, 7, 1);
    issue(32'h2007_0007, 32'h408);
    fast_path(0, 7);
    check_ex("addi7");
    wb_valid = 1'b1; wb_addr = 5'd7;
    handshake();
    wb_valid = 1'b0;
    check("set_wins_busy", dut.u_sb.busy_q, 32'h0000_0088);
    wb(3); wb(7);
    check("busy_clear_3_7", dut.u_sb.busy_q, 0);

    // Reset while in READ discards the instruction
    issue(32'h0022_1820, 32'h500);
    tick();
    check("pre_rst_rf_ena", rf_ena, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rf_ena", rf_ena, 0);
    check("mid_rst_rf_addra", rf_addra, 0);
    check("mid_rst_ex_valid", ex_valid, 0);
    check("mid_rst_ex_pc", ex_pc, 0);
    check("mid_rst_if_ready", if_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_mid_rst_if_ready", if_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_mid_rst_no_emit", ex_valid, 0);
    end
    check("post_mid_rst_busy", dut.u_sb.busy_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
